svm_order_gen: RTL and testbench

- Downstream consumer of the linear SVM classifier.
- Takes each scored sample (valid, Q8.8 decision value, prediction bit) and applies buy/sell thresholds, a symmetric position limit and a post-trade cooldown.
- Emits at most one order at a time on a valid/ready handshake to the order-entry stage.
- Tracks net position and counts qualifying signals that were dropped.

---
 rtl/svm_order_gen.sv | 109 ++++++++++
 tb/tb_svm_order_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/svm_order_gen.sv
// svm_order_gen: turns SVM scores into single in-flight orders with thresholds, position limit and cooldown.
// Define SVM_ORDER_TIMEOUT_EN to withdraw an order that waits more than TIMEOUT_CYCLES for order_ready.
module svm_order_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int POS_WIDTH = 16,
  parameter int CD_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  svm_valid,
  input  logic [DATA_WIDTH-1:0] svm_decision,
  input  logic                  svm_prediction,
  input  logic [DATA_WIDTH-1:0] cfg_buy_thresh,
  input  logic [DATA_WIDTH-1:0] cfg_sell_thresh,
  input  logic [POS_WIDTH-1:0]  cfg_qty,
  input  logic [POS_WIDTH-1:0]  cfg_pos_limit,
  input  logic [CD_WIDTH-1:0]   cfg_cooldown,
  output logic                  order_valid,
  input  logic                  order_ready,
  output logic                  order_side,
  output logic [POS_WIDTH-1:0]  order_qty,
  output logic [DATA_WIDTH-1:0] order_conf,
  output logic [POS_WIDTH-1:0]  position,
  output logic                  busy,
  output logic [15:0]           drop_count,
  output logic                  order_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN} state_t;
  state_t state, state_nx;
  logic [CD_WIDTH-1:0] cd;
  logic buy_sig, sell_sig, qual, buy_ok, sell_ok, launch, hs, withdraw;
  logic signed [POS_WIDTH:0] pos_x, qty_x, lim_x;
  logic [DATA_WIDTH-1:0] abs_dec;
  always_comb begin
    buy_sig = svm_valid & svm_prediction & ($signed(svm_decision) >= $signed(cfg_buy_thresh));
    sell_sig = svm_valid & ~svm_prediction & ($signed(svm_decision) <= $signed(cfg_sell_thresh));
    qual = buy_sig | sell_sig;
    pos_x = {position[POS_WIDTH-1], position};
    qty_x = {1'b0, cfg_qty};
    lim_x = {1'b0, cfg_pos_limit};
    buy_ok = (pos_x + qty_x) <= lim_x;
    sell_ok = (pos_x - qty_x) >= -lim_x;
    hs = order_valid & order_ready;
    launch = (state == IDLE) & enable & (buy_sig ? buy_ok : (sell_sig & sell_ok));
    abs_dec = !svm_decision[DATA_WIDTH-1] ? svm_decision :
              (svm_decision == {1'b1, {(DATA_WIDTH-1){1'b0}}}) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
              -svm_decision;
  end
`ifdef SVM_ORDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic to_q;
  // a handshake on the last allowed cycle wins over withdrawal
  assign withdraw = order_valid & ~order_ready & (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign order_timeout = to_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      to_q <= 1'b0;
    end else begin
      wait_cnt <= launch ? '0 : order_valid ? wait_cnt + 1'b1 : wait_cnt;
      to_q <= withdraw;
    end
  end
`else
  assign withdraw = 1'b0;
  assign order_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = launch ? ISSUE : IDLE;
      ISSUE:    state_nx = hs ? ((cfg_cooldown == '0) ? IDLE : COOLDOWN) : withdraw ? IDLE : ISSUE;
      COOLDOWN: state_nx = (cd <= CD_WIDTH'(1)) ? IDLE : COOLDOWN;
      default:  state_nx = IDLE;
    endcase
  end
  always_comb begin
    order_valid = state == ISSUE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd <= '0;
      order_side <= 1'b0;
      order_qty <= '0;
      order_conf <= '0;
      position <= '0;
      drop_count <= '0;
    end else begin
      if (launch) begin
        order_side <= buy_sig;
        order_qty <= cfg_qty;
        order_conf <= abs_dec;
      end
      if (hs) begin
        position <= order_side ? position + order_qty : position - order_qty;
        cd <= cfg_cooldown;
      end else if (state == COOLDOWN) cd <= cd - 1'b1;
      if (qual & ~launch & ~&drop_count) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_svm_order_gen.sv
// tb_svm_order_gen: directed scenarios plus randomized traffic against a behavioural order-generator model.
module tb_svm_order_gen;
  localparam int TO = 4;
`ifdef SVM_ORDER_TIMEOUT_EN
  localparam int STALL = 3;
`else
  localparam int STALL = 5;
`endif
  logic clk = 0, rst_n = 0, enable = 0, svm_valid = 0, svm_prediction = 0, order_ready = 0;
  logic [15:0] svm_decision = 0, cfg_buy_thresh = 0, cfg_sell_thresh = 0;
  logic [15:0] cfg_qty = 0, cfg_pos_limit = 0, cfg_cooldown = 0;
  logic order_valid, order_side, busy, order_timeout;
  logic [15:0] order_qty, order_conf, position, drop_count;
  int checks = 0, errors = 0;
  bit m_pend, m_side, m_to;
  int m_qty, m_conf, m_pos, m_drop, m_cd, m_wait;

  svm_order_gen #(.DATA_WIDTH(16), .POS_WIDTH(16), .CD_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .svm_valid(svm_valid),
    .svm_decision(svm_decision), .svm_prediction(svm_prediction),
    .cfg_buy_thresh(cfg_buy_thresh), .cfg_sell_thresh(cfg_sell_thresh),
    .cfg_qty(cfg_qty), .cfg_pos_limit(cfg_pos_limit), .cfg_cooldown(cfg_cooldown),
    .order_valid(order_valid), .order_ready(order_ready), .order_side(order_side),
    .order_qty(order_qty), .order_conf(order_conf), .position(position), .busy(busy),
    .drop_count(drop_count), .order_timeout(order_timeout)
  );

  always #5 clk = ~clk;

  function automatic int sx(logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int abs_conf(logic [15:0] v);
    int x = sx(v);
    return x >= 0 ? x : (x == -32768 ? 32767 : -x);
  endfunction

  task automatic model_reset();
    m_pend = 0; m_side = 0; m_to = 0;
    m_qty = 0; m_conf = 0; m_pos = 0; m_drop = 0; m_cd = 0; m_wait = 0;
  endtask

  task automatic model_step();
    int d = sx(svm_decision);
    bit buy = svm_valid && svm_prediction && d >= sx(cfg_buy_thresh);
    bit sell = svm_valid && !svm_prediction && d <= sx(cfg_sell_thresh);
    bit idle = !m_pend && m_cd == 0;
    bit fits = buy ? (m_pos + int'(cfg_qty) <= int'(cfg_pos_limit))
                   : (m_pos - int'(cfg_qty) >= -int'(cfg_pos_limit));
    bit go = (buy || sell) && idle && enable && fits;
    m_to = 0;
    if ((buy || sell) && !go && m_drop < 65535) m_drop++;
    if (m_pend && order_ready) begin
      m_pos += m_side ? m_qty : -m_qty;
      m_pend = 0;
      m_cd = int'(cfg_cooldown);
    end else if (m_pend) begin
`ifdef SVM_ORDER_TIMEOUT_EN
      m_wait++;
      if (m_wait == TO) begin m_pend = 0; m_to = 1; end
`endif
    end else if (m_cd > 0) m_cd--;
    if (go) begin
      m_pend = 1; m_side = buy; m_qty = int'(cfg_qty);
      m_conf = abs_conf(svm_decision); m_wait = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse(input logic [15:0] d, input logic p);
    svm_valid = 1; svm_decision = d; svm_prediction = p;
    tick();
    svm_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++; if (order_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", order_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (position !== 16'd0) begin errors++; $display("FAIL reset_pos got %0h want 0", position); end
    checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0h want 0", drop_count); end
    checks++; if (order_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0b want 0", order_timeout); end
    checks++; if ({order_side, order_qty, order_conf} !== 33'd0) begin errors++; $display("FAIL reset_payload got %0h want 0", {order_side, order_qty, order_conf}); end
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_buy_launch();
    cfg_buy_thresh = 16'h0080; cfg_sell_thresh = 16'hFF80; cfg_qty = 10;
    cfg_pos_limit = 100; cfg_cooldown = 0; order_ready = 1; enable = 1;
    tick();
    pulse(16'h0100, 1);
    checks++; if (order_valid !== 1'b1) begin errors++; $display("FAIL buy_latency got %0b want 1", order_valid); end
    checks++; if ({order_side, order_qty, order_conf} !== {1'b1, 16'd10, 16'h0100}) begin errors++; $display("FAIL buy_payload got %0h want %0h", {order_side, order_qty, order_conf}, {1'b1, 16'd10, 16'h0100}); end
    tick();
    checks++; if (position !== 16'd10) begin errors++; $display("FAIL buy_pos got %0d want 10", position); end
    checks++; if (order_valid !== 1'b0) begin errors++; $display("FAIL buy_drop_valid got %0b want 0", order_valid); end
  endtask

  task automatic test_limit();
    for (int i = 0; i < 8; i++) begin pulse(16'h0100, 1); tick(); end
    cfg_qty = 5;
    pulse(16'h0100, 1); tick();
    checks++; if (position !== 16'd95) begin errors++; $display("FAIL limit_setup_pos got %0d want 95", position); end
    cfg_qty = 10;
    pulse(16'h0100, 1);
    checks++; if (order_valid !== 1'b0) begin errors++; $display("FAIL limit_blocked got %0b want 0", order_valid); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL limit_drop got %0d want 1", drop_count); end
    pulse(16'hFF00, 0);
    checks++; if ({order_valid, order_side} !== 2'b10) begin errors++; $display("FAIL limit_sell got %0b want 10", {order_valid, order_side}); end
    tick();
    checks++; if (position !== 16'd85) begin errors++; $display("FAIL limit_sell_pos got %0d want 85", position); end
  endtask

  task automatic test_backpressure_cooldown();
    order_ready = 0; cfg_cooldown = 3;
    pulse(16'h0200, 1);
    for (int i = 0; i < STALL; i++) begin
      if (i == 1) begin svm_valid = 1; svm_decision = 16'h0300; svm_prediction = 1; cfg_qty = 20; end
      if (i == 2) enable = 0;
      tick();
      svm_valid = 0;
      checks++; if ({order_valid, order_side, order_qty, order_conf} !== {2'b11, 16'd10, 16'h0200}) begin errors++; $display("FAIL stall_hold cyc %0d got %0h want %0h", i, {order_valid, order_side, order_qty, order_conf}, {2'b11, 16'd10, 16'h0200}); end
    end
    enable = 1; cfg_qty = 10;
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL stall_drop got %0d want 2", drop_count); end
    order_ready = 1;
    tick();
    checks++; if (position !== 16'd95) begin errors++; $display("FAIL stall_pos got %0d want 95", position); end
    checks++; if ({order_valid, busy} !== 2'b01) begin errors++; $display("FAIL cd_enter got %0b want 01", {order_valid, busy}); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cd_busy cyc %0d got %0b want 1", i, busy); end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cd_exit got %0b want 0", busy); end
  endtask

  task automatic test_conf_dead_zone();
    cfg_cooldown = 0; order_ready = 1;
    pulse(16'h8000, 0);
    checks++; if ({order_valid, order_side, order_conf} !== {2'b10, 16'h7FFF}) begin errors++; $display("FAIL conf_sat got %0h want %0h", {order_valid, order_side, order_conf}, {2'b10, 16'h7FFF}); end
    tick();
    checks++; if (position !== 16'd85) begin errors++; $display("FAIL conf_pos got %0d want 85", position); end
    pulse(16'h0040, 1);
    checks++; if ({order_valid, drop_count} !== {1'b0, 16'd2}) begin errors++; $display("FAIL dead_zone got %0h want %0h", {order_valid, drop_count}, {1'b0, 16'd2}); end
  endtask

  task automatic test_reset_mid_issue();
    order_ready = 0;
    pulse(16'h0100, 1);
    checks++; if (order_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got %0b want 1", order_valid); end
    rst_n = 0;
    #1;
    checks++; if ({order_valid, busy, position, drop_count} !== 34'd0) begin errors++; $display("FAIL rst_mid got %0h want 0", {order_valid, busy, position, drop_count}); end
    model_reset();
    tick(); tick();
    rst_n = 1;
    order_ready = 1;
    pulse(16'h0100, 1);
    checks++; if (order_valid !== 1'b1) begin errors++; $display("FAIL rst_relaunch got %0b want 1", order_valid); end
    tick();
    checks++; if (position !== 16'd10) begin errors++; $display("FAIL rst_relaunch_pos got %0d want 10", position); end
  endtask

`ifdef SVM_ORDER_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0;
    order_ready = 0; cfg_cooldown = 0;
    pulse(16'h0100, 1);
    for (int i = 0; i < TO; i++) begin
      checks++; if ({order_valid, order_timeout} !== 2'b10) begin errors++; $display("FAIL to_wait cyc %0d got %0b want 10", i, {order_valid, order_timeout}); end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      pulses += order_timeout;
      tick();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulse got %0d want 1", pulses); end
    checks++; if ({order_valid, busy, position} !== {2'b00, 16'd10}) begin errors++; $display("FAIL to_withdraw got %0h want %0h", {order_valid, busy, position}, {2'b00, 16'd10}); end
    order_ready = 1;
    pulse(16'h0100, 1); tick();
    checks++; if (position !== 16'd20) begin errors++; $display("FAIL to_after got %0d want 20", position); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        cfg_buy_thresh = 16'($urandom_range(0, 512));
        cfg_sell_thresh = 16'(-int'($urandom_range(0, 512)));
        cfg_pos_limit = 16'($urandom_range(20, 50));
      end
      cfg_qty = 16'($urandom_range(1, 15));
      cfg_cooldown = 16'($urandom_range(0, 3));
      enable = $urandom_range(0, 7) != 0;
      order_ready = $urandom_range(0, 2) != 0;
      svm_valid = $urandom_range(0, 2) == 0;
      svm_prediction = 1'($urandom_range(0, 1));
      svm_decision = $urandom_range(0, 15) == 0 ? 16'h8000 : 16'(int'($urandom_range(0, 2048)) - 1024);
      tick();
      checks++; if (order_valid !== m_pend) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", i, order_valid, m_pend); end
      checks++; if (busy !== (m_pend || m_cd > 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", i, busy, m_pend || m_cd > 0); end
      checks++; if (position !== 16'(m_pos)) begin errors++; $display("FAIL rnd_pos cyc %0d got %0h want %0h", i, position, 16'(m_pos)); end
      checks++; if (drop_count !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop cyc %0d got %0d want %0d", i, drop_count, m_drop); end
      checks++; if (order_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout cyc %0d got %0b want %0b", i, order_timeout, m_to); end
      if (m_pend) begin
        checks++; if ({order_side, order_qty, order_conf} !== {m_side, 16'(m_qty), 16'(m_conf)}) begin errors++; $display("FAIL rnd_payload cyc %0d got %0h want %0h", i, {order_side, order_qty, order_conf}, {m_side, 16'(m_qty), 16'(m_conf)}); end
      end
    end
    svm_valid = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_buy_launch();
    test_limit();
    test_backpressure_cooldown();
    test_conf_dead_zone();
    test_reset_mid_issue();
`ifdef SVM_ORDER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
